// File: rtl/nano_mem_ctrl.sv
// Memory-port controller for NanoCPU: boot-loads memory from a host stream, then
// arbitrates the single memory port between the CPU and a host debug port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_LOAD | CPU in reset, boot words streamed into memory from pointer
// ST_RUN  | CPU owns port when enabled, host gets idle cycles
// ST_HALT | CPU in reset, host owns every cycle
module nano_mem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_rvalid,
    input  logic              halt_req,
    input  logic              run_req,
    input  logic              reload_req,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_dataW,
    input  logic              cpu_ce,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_dataR,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataW,
    output logic              mem_ce,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dataR,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   load_cnt
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                cpu_rst_q;
    logic                ld_ready_q;
    logic [DATA_W-1:0]   h_rdata_q;
    logic                h_rvalid_q;
    logic                host_rd;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_LOAD;
            ptr_q      <= '0;
            cnt_q      <= '0;
            cpu_rst_q  <= 1'b1;
            ld_ready_q <= 1'b0;
            h_rdata_q  <= '0;
            h_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            // Release only after a full settle cycle in RUN; reassert on leaving RUN.
            cpu_rst_q  <= (state_d != ST_RUN) || (state_q != ST_RUN);
            ld_ready_q <= (state_d == ST_LOAD);
            h_rvalid_q <= host_rd;
            if (host_rd) h_rdata_q <= mem_dataR;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        mem_address = '0;
        mem_dataW   = '0;
        mem_ce      = 1'b0;
        mem_we      = 1'b0;
        h_gnt       = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    mem_address = ptr_q;
                    mem_dataW   = ld_data;
                    mem_ce      = 1'b1;
                    mem_we      = 1'b1;
                    ptr_d       = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    cnt_d       = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                    if (ld_last || (&ptr_q)) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cpu_ce && !cpu_rst_q) begin
                    mem_address = cpu_address;
                    mem_dataW   = cpu_dataW;
                    mem_ce      = 1'b1;
                    mem_we      = cpu_we;
                end else if (h_req) begin
                    mem_address = h_addr;
                    mem_dataW   = h_wdata;
                    mem_ce      = 1'b1;
                    mem_we      = h_we;
                    h_gnt       = 1'b1;
                end
                if (halt_req) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (h_req) begin
                    mem_address = h_addr;
                    mem_dataW   = h_wdata;
                    mem_ce      = 1'b1;
                    mem_we      = h_we;
                    h_gnt       = 1'b1;
                end
                if (reload_req) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end else if (run_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    assign host_rd   = h_gnt && !h_we;
    assign cpu_dataR = mem_dataR;
    assign cpu_rst   = cpu_rst_q;
    assign ld_ready  = ld_ready_q;
    assign h_rdata   = h_rdata_q;
    assign h_rvalid  = h_rvalid_q;
    assign state     = state_q;
    assign load_cnt  = cnt_q;

endmodule

// File: tb/tb_nano_mem_ctrl.sv
// Directed self-checking bench for nano_mem_ctrl with a 256 x 16 sync-write,
// comb-read memory attached to the memory port.
module tb_nano_mem_ctrl;

    logic        ck = 1'b0;
    logic        rst;
    logic        ld_valid, ld_ready, ld_last;
    logic [15:0] ld_data;
    logic        h_req, h_we, h_gnt, h_rvalid;
    logic [7:0]  h_addr;
    logic [15:0] h_wdata, h_rdata;
    logic        halt_req, run_req, reload_req;
    logic [7:0]  cpu_address;
    logic [15:0] cpu_dataW, cpu_dataR;
    logic        cpu_ce, cpu_we, cpu_rst;
    logic [7:0]  mem_address;
    logic [15:0] mem_dataW, mem_dataR;
    logic        mem_ce, mem_we;
    logic [1:0]  state;
    logic [8:0]  load_cnt;

    logic [15:0] mem_arr [256];
    int n_cmp = 0;
    int n_err = 0;

    always #5 ck = ~ck;

    always @(posedge ck) if (mem_ce && mem_we) mem_arr[mem_address] <= mem_dataW;
    assign mem_dataR = mem_arr[mem_address];

    nano_mem_ctrl #(.ADDR_W(8), .DATA_W(16)) dut (
        .ck(ck), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
        .halt_req(halt_req), .run_req(run_req), .reload_req(reload_req),
        .cpu_address(cpu_address), .cpu_dataW(cpu_dataW), .cpu_ce(cpu_ce), .cpu_we(cpu_we),
        .cpu_dataR(cpu_dataR), .cpu_rst(cpu_rst),
        .mem_address(mem_address), .mem_dataW(mem_dataW), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_dataR(mem_dataR), .state(state), .load_cnt(load_cnt)
    );

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ld_valid = 0; ld_last = 0; ld_data = '0;
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        halt_req = 0; run_req = 0; reload_req = 0;
        cpu_address = '0; cpu_dataW = '0; cpu_ce = 0; cpu_we = 0;
        #12;
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d exp 0", state); end
        n_cmp++; if (load_cnt !== 9'd0) begin n_err++; $display("FAIL rst_load_cnt got %0d exp 0", load_cnt); end
        n_cmp++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL rst_cpu_rst got %b exp 1", cpu_rst); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL rst_ld_ready got %b exp 0", ld_ready); end
        n_cmp++; if ({h_gnt, h_rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_host got %b exp 00", {h_gnt, h_rvalid}); end
        n_cmp++; if (h_rdata !== 16'h0) begin n_err++; $display("FAIL rst_h_rdata got %h exp 0000", h_rdata); end
        @(posedge ck); #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL rel_ld_ready got %b exp 0", ld_ready); end
        tick();
        n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL load_ld_ready got %b exp 1", ld_ready); end
    endtask

    task automatic test_boot();
        ld_valid = 1; ld_data = 16'h4000; ld_last = 0;
        #1;
        n_cmp++; if ({mem_ce, mem_we, mem_address} !== {2'b11, 8'h00}) begin n_err++; $display("FAIL boot_port0 got %b%b %h exp 11 00", mem_ce, mem_we, mem_address); end
        tick(); ld_data = 16'h4111;
        tick(); ld_data = 16'h4222; ld_last = 1;
        #1;
        n_cmp++; if (mem_address !== 8'h02) begin n_err++; $display("FAIL boot_addr2 got %h exp 02", mem_address); end
        tick(); ld_valid = 0; ld_last = 0;
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL boot_state got %0d exp 1", state); end
        n_cmp++; if (load_cnt !== 9'd3) begin n_err++; $display("FAIL boot_load_cnt got %0d exp 3", load_cnt); end
        n_cmp++; if ({cpu_rst, ld_ready} !== 2'b10) begin n_err++; $display("FAIL boot_settle got %b exp 10", {cpu_rst, ld_ready}); end
        n_cmp++; if ({mem_arr[0], mem_arr[1], mem_arr[2]} !== {16'h4000, 16'h4111, 16'h4222}) begin n_err++; $display("FAIL boot_mem got %h %h %h exp 4000 4111 4222", mem_arr[0], mem_arr[1], mem_arr[2]); end
        // settle cycle: CPU still in reset, host may be granted
        cpu_ce = 1; cpu_address = 8'h00; h_req = 1; h_we = 0; h_addr = 8'h01;
        #1;
        n_cmp++; if (h_gnt !== 1'b1) begin n_err++; $display("FAIL settle_gnt got %b exp 1", h_gnt); end
        tick(); h_req = 0;
        #1;
        n_cmp++; if (cpu_rst !== 1'b0) begin n_err++; $display("FAIL run_cpu_rst got %b exp 0", cpu_rst); end
        n_cmp++; if ({h_rvalid, h_rdata} !== {1'b1, 16'h4111}) begin n_err++; $display("FAIL settle_read got %b %h exp 1 4111", h_rvalid, h_rdata); end
        n_cmp++; if ({h_gnt, mem_address, cpu_dataR} !== {1'b0, 8'h00, 16'h4000}) begin n_err++; $display("FAIL cpu_fetch0 got %b %h %h exp 0 00 4000", h_gnt, mem_address, cpu_dataR); end
    endtask

    task automatic test_halt();
        halt_req = 1; cpu_ce = 1; cpu_address = 8'h00;
        h_req = 1; h_we = 1; h_addr = 8'h14; h_wdata = 16'h1234;
        #1;
        n_cmp++; if (h_gnt !== 1'b0) begin n_err++; $display("FAIL halt_cycle_gnt got %b exp 0", h_gnt); end
        tick(); halt_req = 0;
        n_cmp++; if ({state, cpu_rst} !== {2'd2, 1'b1}) begin n_err++; $display("FAIL halt_enter got %0d %b exp 2 1", state, cpu_rst); end
        n_cmp++; if ({h_gnt, mem_we, mem_address} !== {2'b11, 8'h14}) begin n_err++; $display("FAIL halt_wr_gnt got %b%b %h exp 11 14", h_gnt, mem_we, mem_address); end
        tick(); h_addr = 8'h0A; h_wdata = 16'hBEEF;
        #1;
        n_cmp++; if ({h_gnt, h_rvalid} !== 2'b10) begin n_err++; $display("FAIL halt_wr2 got %b exp 10", {h_gnt, h_rvalid}); end
        tick(); h_we = 0; h_addr = 8'h14;
        tick(); h_addr = 8'h00;
        #1;
        n_cmp++; if ({h_rvalid, h_rdata} !== {1'b1, 16'h1234}) begin n_err++; $display("FAIL b2b_rd0 got %b %h exp 1 1234", h_rvalid, h_rdata); end
        tick(); h_req = 0;
        n_cmp++; if ({h_rvalid, h_rdata} !== {1'b1, 16'h4000}) begin n_err++; $display("FAIL b2b_rd1 got %b %h exp 1 4000", h_rvalid, h_rdata); end
        tick();
        n_cmp++; if (h_rvalid !== 1'b0) begin n_err++; $display("FAIL rvalid_drop got %b exp 0", h_rvalid); end
        run_req = 1;
        tick(); run_req = 0;
        n_cmp++; if ({state, cpu_rst} !== {2'd1, 1'b1}) begin n_err++; $display("FAIL restart_settle got %0d %b exp 1 1", state, cpu_rst); end
        tick(); cpu_address = 8'h14;
        #1;
        n_cmp++; if ({cpu_rst, cpu_dataR} !== {1'b0, 16'h1234}) begin n_err++; $display("FAIL restart_fetch got %b %h exp 0 1234", cpu_rst, cpu_dataR); end
    endtask

    task automatic test_arbitration();
        cpu_ce = 1; cpu_we = 0; cpu_address = 8'h01;
        h_req = 1; h_we = 0; h_addr = 8'h0A;
        #1;
        n_cmp++; if ({h_gnt, mem_address, cpu_dataR} !== {1'b0, 8'h01, 16'h4111}) begin n_err++; $display("FAIL arb_cpu_wins got %b %h %h exp 0 01 4111", h_gnt, mem_address, cpu_dataR); end
        tick(); cpu_ce = 0;
        #1;
        n_cmp++; if ({h_gnt, mem_address, h_rvalid} !== {1'b1, 8'h0A, 1'b0}) begin n_err++; $display("FAIL arb_host_gnt got %b %h %b exp 1 0a 0", h_gnt, mem_address, h_rvalid); end
        tick(); h_req = 0;
        n_cmp++; if ({h_rvalid, h_rdata} !== {1'b1, 16'hBEEF}) begin n_err++; $display("FAIL arb_read got %b %h exp 1 beef", h_rvalid, h_rdata); end
    endtask

    task automatic test_reload_priority();
        halt_req = 1;
        tick(); halt_req = 0;
        reload_req = 1; run_req = 1;
        tick(); reload_req = 0; run_req = 0;
        n_cmp++; if ({state, load_cnt, ld_ready, cpu_rst} !== {2'd0, 9'd0, 1'b1, 1'b1}) begin n_err++; $display("FAIL reload_prio got %0d %0d %b %b exp 0 0 1 1", state, load_cnt, ld_ready, cpu_rst); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1; ld_data = 16'h5000 + 16'(i);
            tick();
        end
        ld_valid = 0;
        n_cmp++; if (load_cnt !== 9'd5) begin n_err++; $display("FAIL part_load_cnt got %0d exp 5", load_cnt); end
        ld_valid = 1; ld_data = 16'h5555;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({state, load_cnt, ld_ready, cpu_rst} !== {2'd0, 9'd0, 1'b0, 1'b1}) begin n_err++; $display("FAIL areset_ctl got %0d %0d %b %b exp 0 0 0 1", state, load_cnt, ld_ready, cpu_rst); end
        n_cmp++; if ({mem_ce, mem_we, h_gnt, h_rvalid, h_rdata} !== {4'b0000, 16'h0}) begin n_err++; $display("FAIL areset_port got %b%b%b%b %h exp 0000 0000", mem_ce, mem_we, h_gnt, h_rvalid, h_rdata); end
        ld_valid = 0;
        tick(); rst = 1'b1;
        tick();
        ld_valid = 1; ld_data = 16'hA0A0; ld_last = 1;
        #1;
        n_cmp++; if ({mem_we, mem_address} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL reload_addr0 got %b %h exp 1 00", mem_we, mem_address); end
        tick(); ld_valid = 0; ld_last = 0;
        n_cmp++; if ({mem_arr[0], mem_arr[4]} !== {16'hA0A0, 16'h5004}) begin n_err++; $display("FAIL reload_mem got %h %h exp a0a0 5004", mem_arr[0], mem_arr[4]); end
        n_cmp++; if ({state, load_cnt} !== {2'd1, 9'd1}) begin n_err++; $display("FAIL reload_run got %0d %0d exp 1 1", state, load_cnt); end
    endtask

    task automatic test_full_load();
        cpu_ce = 0;
        halt_req = 1;
        tick(); halt_req = 0; reload_req = 1;
        tick(); reload_req = 0;
        for (int i = 0; i < 256; i++) begin
            ld_valid = 1; ld_data = 16'h7000 + 16'(i);
            if (i == 255) begin
                #1;
                n_cmp++; if ({state, mem_address} !== {2'd0, 8'hFF}) begin n_err++; $display("FAIL full_last_addr got %0d %h exp 0 ff", state, mem_address); end
            end
            tick();
        end
        ld_valid = 0;
        n_cmp++; if ({state, load_cnt} !== {2'd1, 9'd256}) begin n_err++; $display("FAIL full_run got %0d %0d exp 1 256", state, load_cnt); end
        n_cmp++; if ({mem_arr[0], mem_arr[128], mem_arr[255]} !== {16'h7000, 16'h7080, 16'h70FF}) begin n_err++; $display("FAIL full_mem got %h %h %h exp 7000 7080 70ff", mem_arr[0], mem_arr[128], mem_arr[255]); end
        // pointer wrapped to 0: a reload-free halt/run does not move it, so reload is the only path back to LOAD
        halt_req = 1;
        tick(); halt_req = 0; reload_req = 1;
        tick(); reload_req = 0;
        ld_valid = 1; ld_data = 16'h1111; ld_last = 1;
        #1;
        n_cmp++; if (mem_address !== 8'h00) begin n_err++; $display("FAIL wrap_addr got %h exp 00", mem_address); end
        tick(); ld_valid = 0; ld_last = 0;
    endtask

    initial begin
        test_reset();
        test_boot();
        test_halt();
        test_arbitration();
        test_reload_priority();
        test_async_reset();
        test_full_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nano_mem_ctrl.md
# nano_mem_ctrl

Memory-port controller between the NanoCPU, its 256 x 16 single-port memory and an external host. After reset it boot-loads a program from a host word stream into memory while holding the CPU in reset, then releases the CPU. During execution it lends idle memory cycles to a host debug port. On request it halts the CPU (held in reset) for exclusive host access or a reload.

## Interface
- ADDR_W, 8, memory address width (depth 2**ADDR_W)
- DATA_W, 16, memory word width
- ck  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- ld_valid / ld_ready  in / out  1 / 1  boot-load stream handshake
- ld_data  in  DATA_W  boot word
- ld_last  in  1  marks final boot word
- h_req  in  1  host access request; held stable until h_gnt
- h_we  in  1  host write (1) / read (0)
- h_addr  in  ADDR_W  host address
- h_wdata  in  DATA_W  host write data
- h_gnt  out  1  host access performed this cycle
- h_rdata  out  DATA_W  registered host read data
- h_rvalid  out  1  one-cycle pulse: h_rdata valid
- halt_req, run_req, reload_req  in  1 each  single-cycle control pulses
- cpu_address, cpu_dataW  in  ADDR_W, DATA_W  CPU memory request
- cpu_ce, cpu_we  in  1, 1  CPU chip enable / write enable
- cpu_dataR  out  DATA_W  equals mem_dataR at all times
- cpu_rst  out  1  active-high CPU reset, registered
- mem_address, mem_dataW  out  ADDR_W, DATA_W  memory port
- mem_ce, mem_we  out  1, 1  memory chip / write enable (sync write, comb read)
- mem_dataR  in  DATA_W  memory read data
- state  out  2  LOAD=0, RUN=1, HALT=2
- load_cnt  out  ADDR_W+1  words written in last/current LOAD

## Operation
- Reset values: state=LOAD, load pointer=0, load_cnt=0, cpu_rst=1, ld_ready=0, h_gnt=0, h_rvalid=0, h_rdata=0.
- LOAD: ld_ready=1 (from first cycle after reset release). Each cycle with ld_valid=1: mem_address=pointer, mem_dataW=ld_data, mem_we=mem_ce=1, pointer++, load_cnt++. Transition to RUN on the accepted word with ld_last=1, or on the accepted word at address 2**ADDR_W-1 (pointer wraps to 0; load_cnt=256). h_gnt=0; halt_req/run_req/reload_req ignored.
- RUN: ld_ready=0. CPU owns the port whenever cpu_ce=1 and cpu_rst=0 (mem_* = cpu_*). Otherwise, if h_req=1: host drives the port, h_gnt=1 combinationally. CPU is never stalled. halt_req -> HALT.
- HALT: CPU held in reset; host owns every cycle (h_gnt=h_req). run_req -> RUN; reload_req -> LOAD with pointer=0, load_cnt=0. reload_req and run_req together: reload wins.
- Host read: on grant with h_we=0, mem_dataR is captured into h_rdata; h_rvalid=1 next cycle. Host write: commits on the granting edge; no h_rvalid.
- Unused port cycles: mem_ce=0, mem_we=0.

## Timing
- cpu_rst=1 in LOAD and HALT. It falls on the second rising edge after state becomes RUN, so the first RUN cycle is a settle cycle where the host may be granted. It rises on the edge that enters HALT or LOAD.
- State transitions take effect at the rising edge following the qualifying input. Grant decisions use the current state: a host request in the cycle halt_req is sampled is still RUN-arbitrated.
- Host read latency: 1 cycle from h_gnt to h_rvalid. Back-to-back granted reads give back-to-back h_rvalid.
- Asynchronous reset mid-LOAD or mid-access: all outputs go to reset values immediately. Partially loaded memory contents are not cleared.

## Test plan
- Boot: stream 'h4000,'h4111,'h4222 with ld_last on third -> mem[0..2] written, load_cnt=3, state=RUN next edge, cpu_rst low one cycle later, CPU fetches from 0.
- Full load: 256 words without ld_last -> last written at 'hFF, pointer wraps to 0, load_cnt=256, RUN entered.
- RUN arbitration: cpu_ce=1 with h_req=1 read 'h0A -> h_gnt=0. Next cycle cpu_ce=0 -> h_gnt=1, h_rvalid next cycle with mem[10] value, CPU access unaffected.
- HALT: halt_req in RUN -> cpu_rst=1 next edge. Host write 'h1234 to 'h14 granted immediately. run_req -> CPU restarts, mem[20]='h1234.
- Reload priority: in HALT assert reload_req and run_req together -> state=LOAD, load_cnt=0, ld_ready=1.
- Async reset mid-LOAD after 5 words -> all outputs at reset values immediately; reload restarts at address 0.
